csr_y_collector: RTL and testbench
==================================

// Module: csr_y_collector
// PURPOSE
//  Memory-side responder for the csr_spmv_0 result port (y_ce0/y_we0/y_address0/y_d0).
//  Captures result-vector writes into an internal register array.
//  Answers the core's y reads with 1-cycle latency, like a BRAM.
//  On ap_done, drains all DEPTH entries in index order over a valid/ready stream for the ILA or host logic.
// PARAMETERS
//  DATA_W   32  width of y_d0, y_q0 and m_data
//  ADDR_W   3   width of y_address0 and m_index
//  DEPTH    8   number of result rows held; must be <= 2**ADDR_W
// PORTS
//  ap_clk       in   1       single clock, rising edge
//  ap_rst_n     in   1       asynchronous, active-low reset
//  y_ce0        in   1       core memory enable
//  y_we0        in   1       core write enable, qualified by y_ce0
//  y_address0   in   ADDR_W  core row address
//  y_d0         in   DATA_W  core write data
//  y_q0         out  DATA_W  read data to core, valid 1 cycle after the read request
//  ap_done      in   1       1-cycle pulse from core: result vector complete
//  m_valid      out  1       drain stream valid
//  m_ready      in   1       drain stream ready
//  m_data       out  DATA_W  y[m_index]
//  m_index      out  ADDR_W  row index of current beat
//  m_last       out  1       high on beat with m_index == DEPTH-1
//  wr_mask      out  DEPTH   bit i set once row i has been written in the current run
//  addr_err     out  1       sticky; set by any access with y_address0 >= DEPTH
//  late_wr_err  out  1       sticky; set by a write while in DRAIN
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=CAPTURE; mem[*]=0; y_q0=0; m_valid=0; m_index=0; m_last=0.
//   - wr_mask=0; addr_err=0; late_wr_err=0.
//   - Reset during DRAIN aborts the drain immediately; no partial beat survives.
//  FSM states: CAPTURE, DRAIN.
//  CAPTURE:
//   - y_ce0&y_we0 with addr<DEPTH: mem[addr]<=y_d0; wr_mask[addr]<=1. Repeated writes overwrite.
//   - y_ce0&!y_we0 with addr<DEPTH: y_q0<=mem[addr] next cycle.
//   - Write and read of the same row in the same cycle are impossible on one port.
//   - y_q0 holds its value when y_ce0=0.
//   - Any addr>=DEPTH: access dropped; addr_err<=1; y_q0<=0 for a read.
//   - ap_done=1: go to DRAIN next cycle. A write in the same cycle as ap_done is committed first.
//  DRAIN:
//   - m_valid=1; m_data=mem[m_index] (combinational from array); m_last=(m_index==DEPTH-1).
//   - Beat completes on m_valid&m_ready: m_index++.
//   - m_data/m_index are stable while m_valid&!m_ready.
//   - Last beat completes: m_valid<=0; m_index<=0; mem[*]<=0; wr_mask<=0; go to CAPTURE.
//   - Throughput is 1 beat/cycle with m_ready held high; DRAIN lasts exactly DEPTH cycles.
//   - Writes in DRAIN: dropped; late_wr_err<=1.
//   - Reads in DRAIN: still served (y_q0=mem[addr] next cycle).
//   - ap_done in DRAIN: ignored.
//  Unwritten rows drain as 0; wr_mask tells the consumer which rows are real.
//  addr_err and late_wr_err clear only on reset.
//  Arithmetic: none on data; m_index counts 0..DEPTH-1 and never wraps past DEPTH-1.
// TESTING
//  T1 basic: write y[0..7]=10..17, pulse ap_done, m_ready=1
//     -> 8 beats, data 10..17, index 0..7, m_last on beat 7.
//     -> wr_mask=8'hFF before drain, 0 after.
//  T2 backpressure: T1 with m_ready toggling 1,0,0,1...
//     -> each beat held stable while stalled; no beat lost or duplicated; m_valid drops after beat 7.
//  T3 sparse/overwrite: write y[2]=5, y[2]=9, y[6]=3, then ap_done
//     -> drain 0,0,9,0,0,0,3,0; wr_mask=8'h44.
//  T4 read-back: write y[4]=0xDEAD, then read y[4] next cycle
//     -> y_q0=0xDEAD one cycle after the read; addr 7 read when DEPTH=6 -> y_q0=0, addr_err=1.
//  T5 races: write y[1]=7 in same cycle as ap_done -> beat 1 data=7.
//     -> Write during DRAIN -> dropped, late_wr_err=1.
//  T6 reset: deassert ap_rst_n mid-drain at beat 3
//     -> m_valid=0 asynchronously; mem cleared; wr_mask=0.
//     -> Post-reset ap_done drains all zeros.

Source files
------------

// File: rtl/csr_y_collector.sv
`default_nettype none
// ============================================================================
//  Module   : csr_y_collector
//  Purpose  : BRAM-like responder for the csr_spmv result port; captures y
//             writes, answers reads, and drains all rows over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module csr_y_collector #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              y_ce0,
  input  logic              y_we0,
  input  logic [ADDR_W-1:0] y_address0,
  input  logic [DATA_W-1:0] y_d0,
  output logic [DATA_W-1:0] y_q0,
  input  logic              ap_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic [DEPTH-1:0]  wr_mask,
  output logic              addr_err,
  output logic              late_wr_err
);

  localparam logic [0:0]        S_CAPTURE = 1'b0;
  localparam logic [0:0]        S_DRAIN   = 1'b1;
  localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH-1);

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic [ADDR_W-1:0] r_index;
  logic [DEPTH-1:0]  r_wr_mask;
  logic              r_addr_err;
  logic              r_late_err;

  logic              w_addr_ok;
  logic              w_wr;
  logic              w_rd;
  logic              w_beat;
  logic              w_last_beat;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_m_data;

  // Extra top bit keeps the range test correct when DEPTH == 2**ADDR_W.
  assign w_addr_ok   = ({1'b0, y_address0} < c_DEPTH);
  assign w_wr        = y_ce0 & y_we0;
  assign w_rd        = y_ce0 & ~y_we0;
  assign w_beat      = (r_state == S_DRAIN) & m_ready;
  assign w_last_beat = w_beat & (r_index == c_LAST);

  always_comb begin
    w_rd_data = '0;
    w_m_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (y_address0 == ADDR_W'(i)) w_rd_data = r_mem[i];
      if (r_index == ADDR_W'(i))    w_m_data  = r_mem[i];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_CAPTURE;
      r_q        <= '0;
      r_index    <= '0;
      r_wr_mask  <= '0;
      r_addr_err <= 1'b0;
      r_late_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Reads are served in both states; out-of-range reads return zero.
      if (w_rd) r_q <= w_addr_ok ? w_rd_data : '0;
      if (y_ce0 && !w_addr_ok) r_addr_err <= 1'b1;

      case (r_state)
        S_CAPTURE: begin
          if (w_wr && w_addr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (y_address0 == ADDR_W'(i)) begin
                r_mem[i]     <= y_d0;
                r_wr_mask[i] <= 1'b1;
              end
            end
          end
          if (ap_done) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_wr) r_late_err <= 1'b1;
          if (w_last_beat) begin
            r_state   <= S_CAPTURE;
            r_index   <= '0;
            r_wr_mask <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
          end else if (w_beat) begin
            r_index <= r_index + 1'b1;
          end
        end
        default: r_state <= S_CAPTURE;
      endcase
    end
  end

  assign y_q0        = r_q;
  assign m_valid     = (r_state == S_DRAIN);
  assign m_data      = w_m_data;
  assign m_index     = r_index;
  assign m_last      = (r_state == S_DRAIN) & (r_index == c_LAST);
  assign wr_mask     = r_wr_mask;
  assign addr_err    = r_addr_err;
  assign late_wr_err = r_late_err;

endmodule
`default_nettype wire

// File: tb/tb_csr_y_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_y_collector
//  Purpose  : Self-checking bench for csr_y_collector against a row-array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_y_collector;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int D  = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          y_ce0 = 1'b0, y_we0 = 1'b0, ap_done = 1'b0, m_ready = 1'b0;
  logic [AW-1:0] y_address0 = '0;
  logic [DW-1:0] y_d0 = '0;
  logic [DW-1:0] y_q0, m_data;
  logic [AW-1:0] m_index;
  logic          m_valid, m_last, addr_err, late_wr_err;
  logic [D-1:0]  wr_mask;

  // Second instance with a non-power-of-two depth for the range-error boundary
  logic          s_ce0 = 1'b0, s_we0 = 1'b0;
  logic [AW-1:0] s_address0 = '0;
  logic [DW-1:0] s_d0 = '0;
  logic [DW-1:0] s_q0, s_m_data;
  logic [AW-1:0] s_m_index;
  logic          s_m_valid, s_m_last, s_addr_err, s_late_wr_err;
  logic [5:0]    s_wr_mask;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mdl_mem [D];
  logic [D-1:0]  mdl_mask;

  always #5 ap_clk = ~ap_clk;

  csr_y_collector #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .y_ce0(y_ce0), .y_we0(y_we0),
    .y_address0(y_address0), .y_d0(y_d0), .y_q0(y_q0), .ap_done(ap_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .wr_mask(wr_mask), .addr_err(addr_err), .late_wr_err(late_wr_err)
  );

  csr_y_collector #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(6)) u_dut6 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .y_ce0(s_ce0), .y_we0(s_we0),
    .y_address0(s_address0), .y_d0(s_d0), .y_q0(s_q0), .ap_done(1'b0),
    .m_valid(s_m_valid), .m_ready(1'b0), .m_data(s_m_data), .m_index(s_m_index),
    .m_last(s_m_last), .wr_mask(s_wr_mask), .addr_err(s_addr_err), .late_wr_err(s_late_wr_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) mdl_mem[i] = '0;
    mdl_mask = '0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    y_ce0 = 1'b1; y_we0 = 1'b1; y_address0 = AW'(a); y_d0 = d;
    tick();
    y_ce0 = 1'b0; y_we0 = 1'b0;
    mdl_mem[a] = d;
    mdl_mask[a] = 1'b1;
  endtask

  task automatic rd(input int a);
    y_ce0 = 1'b1; y_we0 = 1'b0; y_address0 = AW'(a);
    tick();
    y_ce0 = 1'b0;
    check("read_data", y_q0, mdl_mem[a]);
  endtask

  // Pulse ap_done (optionally with a same-cycle write) and consume the drain.
  task automatic drain(input bit rand_ready, input bit late_wr, input int rst_beat,
                       input bit wr_with_done, input int wa, input logic [DW-1:0] wd);
    logic [DW-1:0] exp_q [D];
    int beat, cyc;
    ap_done = 1'b1;
    if (wr_with_done) begin
      y_ce0 = 1'b1; y_we0 = 1'b1; y_address0 = AW'(wa); y_d0 = wd;
    end
    tick();
    ap_done = 1'b0; y_ce0 = 1'b0; y_we0 = 1'b0;
    if (wr_with_done) begin mdl_mem[wa] = wd; mdl_mask[wa] = 1'b1; end
    for (int i = 0; i < D; i++) exp_q[i] = mdl_mem[i];
    beat = 0;
    cyc  = 0;
    while (beat < D && cyc < 100) begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (late_wr && cyc == 0) begin
        y_ce0 = 1'b1; y_we0 = 1'b1; y_address0 = 3'd3; y_d0 = 32'h0BAD;
      end
      check("m_valid", m_valid, 1);
      check("m_index", m_index, beat);
      check("m_data", m_data, exp_q[beat]);
      check("m_last", m_last, (beat == D - 1));
      if (beat == rst_beat) begin
        ap_rst_n = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_index", m_index, 0);
        check("rst_m_data", m_data, 0);
        check("rst_wr_mask", wr_mask, 0);
        model_clear();
        #3;
        ap_rst_n = 1'b1;
        m_ready = 1'b0;
        return;
      end
      tick();
      y_ce0 = 1'b0; y_we0 = 1'b0;
      if (m_ready) beat++;
      cyc++;
    end
    m_ready = 1'b0;
    check("drain_beats", beat, D);
    if (!rand_ready) check("drain_cycles", cyc, D);
    check("post_m_valid", m_valid, 0);
    check("post_m_index", m_index, 0);
    check("post_wr_mask", wr_mask, 0);
    model_clear();
  endtask

  initial begin
    model_clear();
    repeat (2) tick();
    check("reset_m_valid", m_valid, 0);
    check("reset_m_index", m_index, 0);
    check("reset_m_last", m_last, 0);
    check("reset_y_q0", y_q0, 0);
    check("reset_wr_mask", wr_mask, 0);
    check("reset_addr_err", addr_err, 0);
    check("reset_late_err", late_wr_err, 0);
    #2;
    ap_rst_n = 1'b1;
    tick();

    // T1 basic drain, ready held high
    for (int i = 0; i < D; i++) wr(i, 10 + i);
    check("t1_mask", wr_mask, 8'hFF);
    drain(1'b0, 1'b0, -1, 1'b0, 0, '0);

    // T2 random backpressure
    for (int i = 0; i < D; i++) wr(i, 10 + i);
    drain(1'b1, 1'b0, -1, 1'b0, 0, '0);

    // T3 sparse and overwrite
    wr(2, 5); wr(2, 9); wr(6, 3);
    check("t3_mask", wr_mask, 8'h44);
    drain(1'b0, 1'b0, -1, 1'b0, 0, '0);

    // T4 read-back and hold
    wr(4, 32'hDEAD);
    rd(4);
    tick();
    check("t4_hold", y_q0, 32'hDEAD);
    rd(5);

    // T4 range boundary on the DEPTH=6 instance
    s_ce0 = 1'b1; s_we0 = 1'b1; s_address0 = 3'd4; s_d0 = 32'h1234;
    tick();
    s_we0 = 1'b0;
    tick();
    check("d6_read", s_q0, 32'h1234);
    check("d6_err_clear", s_addr_err, 0);
    s_address0 = 3'd7;
    tick();
    s_ce0 = 1'b0;
    check("d6_oob_q", s_q0, 0);
    check("d6_oob_err", s_addr_err, 1);
    check("d6_mask", s_wr_mask, 6'h10);

    // T5 write in the ap_done cycle, then a write during drain
    drain(1'b0, 1'b1, -1, 1'b1, 1, 32'd7);
    check("t5_late_err", late_wr_err, 1);

    // Randomized runs
    for (int run = 0; run < 4; run++) begin
      int nops;
      nops = $urandom_range(4, 16);
      for (int k = 0; k < nops; k++) begin
        int a;
        a = $urandom_range(0, D - 1);
        if ($urandom_range(0, 2) != 0) wr(a, $urandom);
        else rd(a);
      end
      check("rand_mask", wr_mask, mdl_mask);
      drain(1'b1, 1'b0, -1, 1'b0, 0, '0);
    end
    check("main_addr_err", addr_err, 0);

    // T6 reset in the middle of a drain
    for (int i = 0; i < D; i++) wr(i, $urandom | 32'h1);
    drain(1'b0, 1'b0, 3, 1'b0, 0, '0);
    tick();
    check("t6_late_err", late_wr_err, 0);
    check("t6_d6_err", s_addr_err, 0);
    drain(1'b0, 1'b0, -1, 1'b0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
